// File: rtl/pc_gen_ras.sv
// Fetch program counter with trap/redirect/RAS/sequential next-PC selection,
// a valid/ready fetch request, a circular return-address stack and misaligned-target detection.
module pc_gen_ras #(
    parameter int                 XLEN      = 32,
    parameter logic [XLEN-1:0]    RESET_VEC = '0,
    parameter int                 INC       = 4,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            stall_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            ras_push_i,
    input  logic [XLEN-1:0] ras_push_addr_i,
    input  logic            ras_pop_i,
    input  logic            fetch_ready_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_inc_o,
    output logic            misalign_o,
    output logic            ras_empty_o,
    output logic [XLEN-1:0] ras_top_o
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(INC);
    localparam logic [PW-1:0] FULL = PW'(RAS_DEPTH);

    // Handshake: a fetch request is offered while fetch_valid_o=1 and is taken
    // (fire) on an edge where fetch_ready_i=1 and stall_i=0; pc_o holds until then.
    typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_HALT} fetch_state_t;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, cnt_q;
    logic            mis_q;

    logic            fire, load, tgt_mis, pop_take;
    logic [XLEN-1:0] load_tgt;
    logic [AW-1:0]   wr_idx, top_idx;

    assign fetch_valid_o = (state_q == FS_RUN);
    assign pc_o          = pc_q;
    assign pc_inc_o      = pc_q + XLEN'(INC);
    assign misalign_o    = mis_q;
    assign ras_empty_o   = (cnt_q == '0);

    assign wr_idx    = ptr_q[AW-1:0];
    assign top_idx   = AW'(ptr_q[AW-1:0] - 1'b1);
    assign ras_top_o = ras_empty_o ? '0 : ras_mem[top_idx];

    assign fire     = fetch_valid_o & fetch_ready_i & ~stall_i;
    assign load     = trap_valid_i | redirect_valid_i;
    assign load_tgt = trap_valid_i ? trap_vec_i : redirect_pc_i;
    assign tgt_mis  = load & (load_tgt[IW-1:0] != '0);
    assign pop_take = fire & ras_pop_i & ~ras_empty_o & ~load;

    always_comb begin
        pc_d = pc_q;
        if (load)          pc_d = load_tgt;
        else if (pop_take) pc_d = ras_top_o;
        else if (fire)     pc_d = pc_inc_o;
    end

    // A misaligned load parks fetch in HALT until an aligned trap/redirect arrives.
    always_comb begin
        state_d = state_q;
        if (load)                   state_d = tgt_mis ? FS_HALT : FS_RUN;
        else if (state_q == FS_IDLE) state_d = FS_RUN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_VEC;
            mis_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= tgt_mis;
            if (trap_valid_i) begin
                ptr_q <= '0;
                cnt_q <= '0;
            end else if (pop_take && !ras_push_i) begin
                ptr_q <= PW'(top_idx);
                cnt_q <= cnt_q - 1'b1;
            end else if (!pop_take && ras_push_i) begin
                ptr_q <= PW'(AW'(wr_idx + 1'b1));
                if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Push+pop together rewrites the slot the pop just consumed.
    always_ff @(posedge CLK) begin
        if (!RST && !trap_valid_i && ras_push_i) begin
            if (pop_take) ras_mem[top_idx] <= ras_push_addr_i;
            else          ras_mem[wr_idx]  <= ras_push_addr_i;
        end
    end
endmodule
